fc_argmax_1: RTL and testbench

FC_ARGMAX_1 -- requirements
Module: fc_argmax_1

---
 rtl/fc_argmax_1_pkg.sv | 25 ++
 rtl/fc_argmax_1_max_tree.sv | 28 ++
 rtl/fc_argmax_1.sv | 173 +++++++++++++++++
 tb/tb_fc_argmax_1.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fc_argmax_1_pkg.sv
// Shared sizing defaults and FSM encoding for the FC output-layer argmax block.
// The defaults describe the standard 10-class head read from 4 banks.
package fc_argmax_1_pkg;

    localparam int FC_DATA_WIDTH_DEF  = 16;
    localparam int FC_PO_DEF          = 4;
    localparam int FC_OUTNEURON_DEF   = 10;
    localparam int FC_ADDR_WIDTH_DEF  = 4;
    localparam int FC_RD_LATENCY_DEF  = 2;
    localparam int FC_CLASS_IDX_DEF   = 4;

    function automatic int fc_ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    localparam int FC_ARGMAX_WORDS = fc_ceil_div(FC_OUTNEURON_DEF, FC_PO_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fc_state_t;

endpackage

// File: rtl/fc_argmax_1_max_tree.sv
// Combinational signed max across PO lanes; only lanes with mask set compete,
// and ties keep the lowest lane.
module fc_max_tree #(
    parameter int DW = 16,
    parameter int PO = 4,
    parameter int LW = 2
) (
    input  logic [PO-1:0][DW-1:0] data,
    input  logic [PO-1:0]         mask,
    output logic [DW-1:0]         max_val,
    output logic [LW-1:0]         max_lane,
    output logic                  any_vld
);

    always_comb begin
        max_val  = '0;
        max_lane = '0;
        any_vld  = 1'b0;
        for (int k = 0; k < PO; k++) begin
            if (mask[k] && (!any_vld || $signed(data[k]) > $signed(max_val))) begin
                max_val  = data[k];
                max_lane = LW'(k);
                any_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fc_argmax_1.sv
// Streams the FC output-neuron RAM word by word and reports the index and value
// of the largest signed neuron, pulsing done once per run.
module fc_argmax_1
    import fc_argmax_1_pkg::*;
#(
    parameter int DATA_WIDTH_FC           = FC_DATA_WIDTH_DEF,
    parameter int PO                      = FC_PO_DEF,
    parameter int OUTNEURON               = FC_OUTNEURON_DEF,
    parameter int FC_OUTNEURON_ADDR_WIDTH = FC_ADDR_WIDTH_DEF,
    parameter int FC_OUT_RD_LATENCY       = FC_RD_LATENCY_DEF,
    parameter int FC_CLASS_IDX_WIDTH      = FC_CLASS_IDX_DEF
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    output logic                              busy,
    output logic [FC_OUTNEURON_ADDR_WIDTH-1:0] address_a_t_use_out,
    output logic [FC_OUTNEURON_ADDR_WIDTH-1:0] address_b_t_use_out,
    output logic                              rden_a_use_out,
    output logic                              rden_b_use_out,
    output logic                              wren_a_use_out,
    output logic                              wren_b_use_out,
    input  logic [DATA_WIDTH_FC*PO-1:0]       fc_q_a_all_out,
    output logic [FC_CLASS_IDX_WIDTH-1:0]     class_idx,
    output logic [DATA_WIDTH_FC-1:0]          class_max,
    output logic                              done
);

    localparam int WORDS = fc_ceil_div(OUTNEURON, PO);
    localparam int LAT   = FC_OUT_RD_LATENCY;
    localparam int AW    = FC_OUTNEURON_ADDR_WIDTH;
    localparam int DW    = DATA_WIDTH_FC;
    localparam int CIW   = FC_CLASS_IDX_WIDTH;
    localparam int LW    = (PO > 1) ? $clog2(PO) : 1;
    localparam int CMAX  = (WORDS > LAT) ? WORDS : LAT;
    localparam int CNT_W = $clog2(CMAX + 1);

    fc_state_t          state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic               rd_en;
    logic [AW-1:0]      rd_addr;

    // vld_pipe[i]/word_pipe[i]: a read issued i cycles ago; stage LAT lines up with q.
    logic [LAT:1]          vld_pipe;
    logic [LAT:1][AW-1:0]  word_pipe;

    logic [PO-1:0][DW-1:0] lane_data;
    logic [PO-1:0]         lane_ok;
    logic [DW-1:0]         t_max;
    logic [LW-1:0]         t_lane;
    logic                  t_any;

    logic [DW-1:0]         run_max;
    logic [CIW-1:0]        run_idx;
    logic                  have_max;
    logic                  take;
    logic [DW-1:0]         merged_max;
    logic [CIW-1:0]        merged_idx;
    logic [CIW-1:0]        cand_idx;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (enable) state_nxt = ST_READ;
            end
            ST_READ: begin
                if (cnt == CNT_W'(WORDS - 1)) begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt == CNT_W'(LAT - 1)) begin
                    state_nxt = ST_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign rd_en   = (state == ST_READ);
    assign rd_addr = rd_en ? AW'(cnt) : '0;

    assign busy                = (state != ST_IDLE);
    assign done                = (state == ST_DONE);
    assign rden_a_use_out      = rd_en;
    assign address_a_t_use_out = rd_addr;
    assign address_b_t_use_out = '0;
    assign rden_b_use_out      = 1'b0;
    assign wren_a_use_out      = 1'b0;
    assign wren_b_use_out      = 1'b0;

    assign lane_data = fc_q_a_all_out;

    // Padding lanes past OUTNEURON are masked out so their contents never matter.
    always_comb begin
        lane_ok = '0;
        for (int k = 0; k < PO; k++)
            lane_ok[k] = vld_pipe[LAT] && ((int'(word_pipe[LAT]) * PO + k) < OUTNEURON);
    end

    fc_max_tree #(
        .DW (DW),
        .PO (PO),
        .LW (LW)
    ) u_max_tree (
        .data     (lane_data),
        .mask     (lane_ok),
        .max_val  (t_max),
        .max_lane (t_lane),
        .any_vld  (t_any)
    );

    // Strictly-greater replacement keeps the earliest index on ties across words.
    always_comb begin
        cand_idx   = CIW'(int'(word_pipe[LAT]) * PO + int'(t_lane));
        take       = t_any && (!have_max || $signed(t_max) > $signed(run_max));
        merged_max = take ? t_max    : run_max;
        merged_idx = take ? cand_idx : run_idx;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            vld_pipe  <= '0;
            word_pipe <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            have_max  <= 1'b0;
            class_idx <= '0;
            class_max <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            vld_pipe[1]  <= rd_en;
            word_pipe[1] <= rd_addr;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                word_pipe[i] <= word_pipe[i-1];
            end
            if (state == ST_IDLE && enable) begin
                have_max <= 1'b0;
            end else if (take) begin
                run_max  <= t_max;
                run_idx  <= cand_idx;
                have_max <= 1'b1;
            end
            // The last word lands in the final DRAIN cycle, so fold it in here.
            if (state == ST_DRAIN && state_nxt == ST_DONE) begin
                class_idx <= merged_idx;
                class_max <= merged_max;
            end
        end
    end

endmodule

// File: tb/tb_fc_argmax_1.sv
// Self-checking bench for fc_argmax_1: directed vector table, random runs
// against an argmax reference, enable-hold and mid-run reset sequences.
module tb_fc_argmax_1;

    localparam int DW   = 16;
    localparam int PO   = 4;
    localparam int NN   = 10;
    localparam int AW   = 4;
    localparam int NPAD = 12;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          busy;
    logic [AW-1:0] address_a, address_b;
    logic          rden_a, rden_b, wren_a, wren_b;
    logic [DW*PO-1:0] q_a;
    logic [3:0]    class_idx;
    logic [DW-1:0] class_max;
    logic          done;

    int n_vec = 0;
    int n_err = 0;

    logic [DW*PO-1:0] mem [0:15];
    logic [DW*PO-1:0] q1;

    always #5 clock = ~clock;

    fc_argmax_1 dut (
        .clock               (clock),
        .reset               (reset),
        .enable              (enable),
        .busy                (busy),
        .address_a_t_use_out (address_a),
        .address_b_t_use_out (address_b),
        .rden_a_use_out      (rden_a),
        .rden_b_use_out      (rden_b),
        .wren_a_use_out      (wren_a),
        .wren_b_use_out      (wren_b),
        .fc_q_a_all_out      (q_a),
        .class_idx           (class_idx),
        .class_max           (class_max),
        .done                (done)
    );

    // Two-cycle RAM; non-read cycles return noise so stray sampling is visible.
    always @(posedge clock) begin
        q1  <= rden_a ? mem[address_a] : {$urandom, $urandom};
        q_a <= q1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0)
            chk("const_ports", int'({address_b, rden_b, wren_a, wren_b}), 0);
    end

    task automatic load(input int v[NPAD]);
        for (int w = 0; w < 16; w++) mem[w] = {$urandom, $urandom};
        for (int i = 0; i < NPAD; i++) mem[i / PO][(i % PO) * DW +: DW] = DW'(v[i]);
    endtask

    // Reference: first maximum over the valid neurons.
    function automatic void ref_argmax(input int v[NPAD], output int idx, output int mx);
        idx = 0;
        mx  = v[0];
        for (int i = 1; i < NN; i++)
            if (v[i] > mx) begin
                mx  = v[i];
                idx = i;
            end
    endfunction

    task automatic run_case(input string nm, input int v[NPAD], input int eidx, input int emax);
        int done_at;
        load(v);
        @(negedge clock);
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        done_at = -1;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) @(negedge clock);
            chk({nm, "_rden_a"}, int'(rden_a), (k <= 3) ? 1 : 0);
            chk({nm, "_addr_a"}, int'(address_a), (k <= 3) ? k - 1 : 0);
            chk({nm, "_busy"}, int'(busy), (k <= 6) ? 1 : 0);
            if (done && done_at < 0) done_at = k;
            if (k == 6 || k == 9) begin
                chk({nm, "_idx"}, int'(class_idx), eidx);
                chk({nm, "_max"}, int'($signed(class_max)), emax);
            end
        end
        chk({nm, "_latency"}, done_at, 6);
    endtask

    typedef struct {
        string nm;
        int    n[NPAD];
        int    eidx;
        int    emax;
    } vec_t;

    vec_t tbl[6];
    int   rv[NPAD];
    int   ei, em, busy_low;

    initial begin
        tbl[0].nm = "spec_mix";  tbl[0].n = '{-5, 3, 7, 2, 1, 9, -1, 0, 4, 6, 100, 100};
        tbl[0].eidx = 5; tbl[0].emax = 9;
        tbl[1].nm = "all_tie";   tbl[1].n = '{12, 12, 12, 12, 12, 12, 12, 12, 12, 12, 12, 12};
        tbl[1].eidx = 0; tbl[1].emax = 12;
        tbl[2].nm = "tie_5_9";   tbl[2].n = '{0, 0, 0, 0, 0, 40, 0, 0, 0, 40, 0, 0};
        tbl[2].eidx = 5; tbl[2].emax = 40;
        tbl[3].nm = "ascending"; tbl[3].n = '{-100, -99, -98, -97, -96, -95, -94, -93, -92, -91, 500, 500};
        tbl[3].eidx = 9; tbl[3].emax = -91;
        tbl[4].nm = "all_min";   tbl[4].n = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, 32767, 32767};
        tbl[4].eidx = 0; tbl[4].emax = -32768;
        tbl[5].nm = "last_wins"; tbl[5].n = '{-2, -2, -2, -2, -2, -2, -2, -2, -2, -1, 32767, 32767};
        tbl[5].eidx = 9; tbl[5].emax = -1;

        reset  = 1'b1;
        enable = 1'b0;
        for (int w = 0; w < 16; w++) mem[w] = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rden", int'(rden_a), 0);
        chk("rst_class", int'({class_idx, class_max}), 0);
        reset = 1'b0;
        @(negedge clock);

        for (int t = 0; t < 6; t++) run_case(tbl[t].nm, tbl[t].n, tbl[t].eidx, tbl[t].emax);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NPAD; i++)
                rv[i] = (r % 2 == 0) ? int'($urandom_range(0, 7)) - 4
                                     : int'($signed(16'($urandom)));
            ref_argmax(rv, ei, em);
            run_case("random", rv, ei, em);
        end

        // enable held across two back-to-back runs
        load(tbl[0].n);
        @(negedge clock);
        enable   = 1'b1;
        busy_low = 0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clock);
            chk("hold_done", int'(done), (k == 6 || k == 13) ? 1 : 0);
            chk("hold_busy", int'(busy), (k == 7 || k >= 14) ? 0 : 1);
            if (k == 13) chk("hold_idx", int'(class_idx), 5);
            if (k == 13) enable = 1'b0;
        end

        // reset during DRAIN aborts without done
        load(tbl[3].n);
        @(negedge clock);
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        repeat (3) @(negedge clock);
        chk("pre_rst_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rden", int'(rden_a), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_class", int'({class_idx, class_max}), 0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("abort_no_done", int'(done), 0);
        end
        run_case("after_rst", tbl[2].n, tbl[2].eidx, tbl[2].emax);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
